// File: rtl/rat_pkg.sv
// rat_pkg: shared direction encoding, inverse helper and replay FSM states for the rat path tracker.
package rat_pkg;
    typedef enum logic [1:0] {
        DIR_XM = 2'b00,
        DIR_YP = 2'b01,
        DIR_YM = 2'b10,
        DIR_XP = 2'b11
    } dir_t;
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_REPLAY = 1'b1;
    // The encoding is chosen so that the opposite move is the bitwise complement.
    function automatic dir_t inv_dir(input dir_t d);
        return dir_t'(~d);
    endfunction
endpackage

// File: rtl/path_lifo.sv
// path_lifo: move-history stack with push/pop, top-of-stack view and an async random read port.
module path_lifo #(
    parameter int DEPTH = 16,
    parameter int W = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    din,
    input  logic [AW-1:0]   rd_addr,
    output logic [W-1:0]    top,
    output logic [W-1:0]    rd_data,
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty
);
    logic [W-1:0]    mem_q [DEPTH];
    logic [CNTW-1:0] count_q, count_d, top_idx;
    logic            push_ok, pop_ok;
    assign full    = count_q == CNTW'(DEPTH);
    assign empty   = count_q == '0;
    assign push_ok = push & !full;
    assign pop_ok  = pop & !empty;
    assign top_idx = count_q - CNTW'(1);
    assign top     = mem_q[top_idx[AW-1:0]];
    assign rd_data = mem_q[rd_addr];
    assign count   = count_q;
    // Next occupancy: push and pop are never requested together by the owner.
    always_comb begin
        count_d = push_ok ? count_q + CNTW'(1) : pop_ok ? count_q - CNTW'(1) : count_q;
    end
    // Occupancy register; storage contents need no reset since count gates them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    // Storage write at the current fill level.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[count_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rat_path_tracker.sv
// rat_path_tracker: bounded position tracker with move history, undo and oldest-first path replay.
module rat_path_tracker
    import rat_pkg::*;
#(
    parameter int CW = 4,
    parameter int DEPTH = 16,
    parameter int GOAL_X = 2**CW - 1,
    parameter int GOAL_Y = 2**CW - 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step_req,
    input  logic [1:0]      step_dir,
    input  logic            blocked,
    input  logic            back_req,
    input  logic            replay_start,
    input  logic            mv_ready,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic [CNTW-1:0] depth,
    output logic            full,
    output logic            empty,
    output logic            invalid,
    output logic            finish,
    output logic            cmd_ack,
    output logic            cmd_nack,
    output logic [1:0]      back_dir,
    output logic            replaying,
    output logic            mv_valid,
    output logic [1:0]      mv_dir,
    output logic            mv_last
);
    localparam logic [CW-1:0] MAXC = '1;
    state_t          state_q, state_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]      back_dir_q, back_dir_d, top_raw;
    logic            ack_q, ack_d, nack_q, nack_d;
    logic            idle, do_back, do_step, do_replay, move_en, hs;
    dir_t            sdir, mdir;
    path_lifo #(.DEPTH(DEPTH), .W(2)) u_lifo (
        .clk     (clk),
        .rst     (rst),
        .push    (do_step),
        .pop     (do_back),
        .din     (step_dir),
        .rd_addr (rd_ptr_q),
        .top     (top_raw),
        .rd_data (mv_dir),
        .count   (depth),
        .full    (full),
        .empty   (empty)
    );
    assign sdir      = dir_t'(step_dir);
    assign invalid   = blocked | (sdir == DIR_XM && x_q == '0) | (sdir == DIR_YP && y_q == MAXC)
                     | (sdir == DIR_YM && y_q == '0) | (sdir == DIR_XP && x_q == MAXC);
    assign idle      = state_q == ST_IDLE;
    assign replaying = state_q == ST_REPLAY;
    assign mv_valid  = replaying;
    assign mv_last   = replaying & (CNTW'(rd_ptr_q) == depth - CNTW'(1));
    assign hs        = mv_valid & mv_ready;
    assign do_back   = idle & back_req & !empty;
    assign do_step   = idle & !back_req & step_req & !invalid & !full;
    assign do_replay = idle & !back_req & !step_req & replay_start & !empty;
    assign move_en   = do_back | do_step;
    assign mdir      = do_back ? inv_dir(dir_t'(top_raw)) : sdir;
    assign x         = x_q;
    assign y         = y_q;
    assign finish    = x_q == CW'(GOAL_X) && y_q == CW'(GOAL_Y);
    assign cmd_ack   = ack_q;
    assign cmd_nack  = nack_q;
    assign back_dir  = back_dir_q;
    // Arbitration, position update and replay sequencing; dropped lower-priority requests get no response.
    always_comb begin
        x_d        = !move_en ? x_q : mdir == DIR_XM ? x_q - CW'(1) : mdir == DIR_XP ? x_q + CW'(1) : x_q;
        y_d        = !move_en ? y_q : mdir == DIR_YM ? y_q - CW'(1) : mdir == DIR_YP ? y_q + CW'(1) : y_q;
        ack_d      = do_back | do_step | do_replay;
        nack_d     = idle ? (back_req ? empty : step_req ? (invalid | full) : (replay_start & empty))
                          : (step_req | back_req | replay_start);
        back_dir_d = do_back ? top_raw : back_dir_q;
        state_d    = do_replay ? ST_REPLAY : (hs & mv_last) ? ST_IDLE : state_q;
        rd_ptr_d   = do_replay ? '0 : hs ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end
    // Control and position state; reset also aborts an in-flight replay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            rd_ptr_q   <= '0;
            back_dir_q <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rd_ptr_q   <= rd_ptr_d;
            back_dir_q <= back_dir_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
        end
    end
endmodule
